// File: rtl/gray2rgb_pkg.sv
// Shared types and constants for the gray-to-RGB565 custom-instruction unit.
// Imported by gray8_to_rgb565 and gray_to_rgb565_ise.
package gray2rgb_pkg;

  // Opcode field carried in valueB[1:0]; values 2 and 3 are reserved.
  localparam logic [1:0] OP_CONVERT = 2'd0;
  localparam logic [1:0] OP_FETCH   = 2'd1;

  // Number of gray pixels packed into one CONVERT operand.
  localparam int NPIX = 4;

  // One RGB565 pixel: {R[4:0], G[5:0], B[4:0]}.
  typedef logic [15:0] rgb565_t;

  // Instruction sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  // Selects gray pixel idx from the packed 32-bit operand (p0 in the low byte).
  function automatic logic [7:0] gray_pick(input logic [31:0] packed_gray,
                                           input logic [1:0]  idx);
    logic [7:0] sel;
    case (idx)
      2'd0:    sel = packed_gray[7:0];
      2'd1:    sel = packed_gray[15:8];
      2'd2:    sel = packed_gray[23:16];
      2'd3:    sel = packed_gray[31:24];
      default: sel = 8'h00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gray8_to_rgb565.sv
// Combinational 8-bit gray to RGB565 expander.
// Build option GRAY2RGB_ROUND_EN: when defined, each channel is rounded to
// nearest and saturated; otherwise the low gray bits are simply truncated.
module gray8_to_rgb565
  import gray2rgb_pkg::*;
(
  input  logic [7:0] gray,
  output rgb565_t    pixel
);

`ifdef GRAY2RGB_ROUND_EN
  logic [8:0] r_sum_s;
  logic [8:0] g_sum_s;
  logic [4:0] r5_s;
  logic [5:0] g6_s;

  // Round-to-nearest with a 9-bit sum; 0xFF would overflow the field, so clamp.
  always_comb begin
    r_sum_s = {1'b0, gray} + 9'd4;
    g_sum_s = {1'b0, gray} + 9'd2;
    if (r_sum_s[8:3] > 6'd31) begin
      r5_s = 5'd31;
    end else begin
      r5_s = r_sum_s[7:3];
    end
    if (g_sum_s[8:2] > 7'd63) begin
      g6_s = 6'd63;
    end else begin
      g6_s = g_sum_s[7:2];
    end
    pixel = {r5_s, g6_s, r5_s};
  end
`else
  // Truncating expansion: keep the top bits of gray in each channel.
  always_comb begin
    pixel = {gray[7:3], gray[7:2], gray[7:3]};
  end
`endif

endmodule

// File: rtl/gray_to_rgb565_ise.sv
// Multi-cycle custom instruction: expands four packed gray pixels into four
// RGB565 pixels, one per cycle. CONVERT returns pixels 1:0, FETCH returns
// pixels 3:2 from the internal buffer. result is zero whenever done is low
// so it can be OR-combined with other units on the custom-instruction bus.
// Build option GRAY2RGB_ROUND_EN selects rounding conversion (see
// gray8_to_rgb565); latency and protocol do not change.
module gray_to_rgb565_ise
  import gray2rgb_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  state_t      state_r;
  logic [1:0]  idx_r;
  logic [31:0] gray_r;
  rgb565_t     pix_buf_r [NPIX];
  logic        buf_valid_r;
  logic        done_r;
  logic [31:0] result_r;

  logic        accept_s;
  logic [1:0]  opcode_s;
  logic [7:0]  gray_sel_s;
  rgb565_t     pixel_s;
  logic        unused_ok_s;

  // Upper opcode bits carry no meaning for this unit.
  assign unused_ok_s = ^valueB[31:2];

  // Decode an instruction addressed to this unit and its opcode.
  always_comb begin
    accept_s = start && (iseId == customInstructionId);
    opcode_s = valueB[1:0];
  end

  // Feed the single converter with the pixel selected by the running index.
  always_comb begin
    gray_sel_s = gray_pick(gray_r, idx_r);
  end

  gray8_to_rgb565 u_conv (
    .gray  (gray_sel_s),
    .pixel (pixel_s)
  );

  // Instruction sequencer with registered done/result and pixel buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= 2'd0;
      gray_r      <= 32'h0000_0000;
      buf_valid_r <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= 32'h0000_0000;
      for (int i = 0; i < NPIX; i++) begin
        pix_buf_r[i] <= 16'h0000;
      end
    end else begin
      case (state_r)
        IDLE: begin
          done_r   <= 1'b0;
          result_r <= 32'h0000_0000;
          if (accept_s) begin
            case (opcode_s)
              OP_CONVERT: begin
                // Stale pixels 3:2 must not be fetchable while refilling.
                gray_r      <= valueA;
                buf_valid_r <= 1'b0;
                idx_r       <= 2'd0;
                state_r     <= CONV;
              end
              OP_FETCH: begin
                if (buf_valid_r) begin
                  result_r <= {pix_buf_r[3], pix_buf_r[2]};
                end else begin
                  result_r <= 32'h0000_0000;
                end
                done_r  <= 1'b1;
                state_r <= RESP;
              end
              default: begin
                // Reserved opcodes complete with a zero result, buffer untouched.
                result_r <= 32'h0000_0000;
                done_r   <= 1'b1;
                state_r  <= RESP;
              end
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        CONV: begin
          pix_buf_r[idx_r] <= pixel_s;
          if (idx_r == 2'(NPIX - 1)) begin
            // Pixels 1:0 were written in earlier CONV cycles.
            buf_valid_r <= 1'b1;
            done_r      <= 1'b1;
            result_r    <= {pix_buf_r[1], pix_buf_r[0]};
            idx_r       <= 2'd0;
            state_r     <= RESP;
          end else begin
            idx_r   <= idx_r + 2'd1;
            state_r <= CONV;
          end
        end
        RESP: begin
          done_r   <= 1'b0;
          result_r <= 32'h0000_0000;
          state_r  <= IDLE;
        end
        default: begin
          done_r   <= 1'b0;
          result_r <= 32'h0000_0000;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_gray_to_rgb565_ise.sv
// Directed self-checking bench for gray_to_rgb565_ise.
// Expected values are hand-computed; GRAY2RGB_ROUND_EN selects the rounded set.
module tb_gray_to_rgb565_ise;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  iseId;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic done_prev = 1'b0;

`ifdef GRAY2RGB_ROUND_EN
  localparam logic [31:0] EXP_CONV1  = 32'h8410_8410;
`else
  localparam logic [31:0] EXP_CONV1  = 32'h8410_7BEF;
`endif
  localparam logic [31:0] EXP_FETCH1 = 32'h0000_FFFF;
  localparam logic [31:0] EXP_CONV2  = 32'h4208_630C;
  localparam logic [31:0] EXP_FETCH2 = 32'h1082_2104;

  gray_to_rgb565_ise #(.customInstructionId(8'd0)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .iseId  (iseId),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Bus rules observed every cycle in every scenario.
  always @(negedge clock) begin
    if (!reset) begin
      if (!done) check("result_zero_when_idle", result, 32'h0);
      check("done_two_cycles", {31'b0, done & done_prev}, 32'h0);
    end
    done_prev = done;
  end

  // Issue one instruction in cycle T and report cycles until done (0 = none in 20).
  task automatic issue(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    bit found;
    @(posedge clock); #1;
    start = 1'b1; iseId = id; valueA = a; valueB = b;
    @(posedge clock); #1;
    start = 1'b0; valueA = 32'h0; valueB = 32'h0;
    found = 1'b0; lat = 0; res = 32'hDEAD_BEEF;
    for (int i = 1; i <= 20; i++) begin
      if (!found) begin
        @(negedge clock);
        if (done) begin
          found = 1'b1; lat = i; res = result;
        end else begin
          @(posedge clock); #1;
        end
      end
    end
  endtask

  // Count done pulses over n cycles.
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (done) cnt++;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    logic [31:0] res;

    reset = 1'b1; start = 1'b0; iseId = 8'd0; valueA = 32'h0; valueB = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // FETCH with an empty buffer.
    issue(8'd0, 32'h0, 32'h1, lat, res);
    check("fetch_empty_lat", lat, 32'd1);
    check("fetch_empty_res", res, 32'h0);

    // CONVERT p0=7F p1=80 p2=FF p3=00, then FETCH twice.
    issue(8'd0, 32'h00FF_807F, 32'h0, lat, res);
    check("conv1_lat", lat, 32'd5);
    check("conv1_res", res, EXP_CONV1);
    issue(8'd0, 32'h0, 32'h1, lat, res);
    check("fetch1_lat", lat, 32'd1);
    check("fetch1_res", res, EXP_FETCH1);
    issue(8'd0, 32'h0, 32'h1, lat, res);
    check("fetch1_repeat_res", res, EXP_FETCH1);

    // Reserved opcodes leave the buffer alone.
    issue(8'd0, 32'hFFFF_FFFF, 32'h2, lat, res);
    check("rsv2_lat", lat, 32'd1);
    check("rsv2_res", res, 32'h0);
    issue(8'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
    check("rsv3_lat", lat, 32'd1);
    check("rsv3_res", res, 32'h0);
    issue(8'd0, 32'h0, 32'h1, lat, res);
    check("fetch_after_rsv_res", res, EXP_FETCH1);

    // CONVERT with junk in valueB[31:2]; values exact in both builds.
    issue(8'd0, 32'h1020_4060, 32'hFFFF_FFFC, lat, res);
    check("conv2_lat", lat, 32'd5);
    check("conv2_res", res, EXP_CONV2);
    issue(8'd0, 32'h0, 32'hABCD_0001, lat, res);
    check("fetch2_res", res, EXP_FETCH2);

    // Foreign iseId: no response, unit stays idle.
    @(posedge clock); #1;
    start = 1'b1; iseId = 8'h05; valueA = 32'h1234_5678; valueB = 32'h0;
    @(posedge clock); #1;
    start = 1'b0; iseId = 8'd0;
    count_done(10, cnt);
    check("foreign_id_no_done", cnt, 32'd0);
    issue(8'd0, 32'h0, 32'h1, lat, res);
    check("foreign_id_idle_lat", lat, 32'd1);
    check("foreign_id_buf_kept", res, EXP_FETCH2);

    // Reset at T+2 of a CONVERT: no done, buffer cleared.
    @(posedge clock); #1;
    start = 1'b1; iseId = 8'd0; valueA = 32'hFFFF_FFFF; valueB = 32'h0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    count_done(10, cnt);
    check("abort_no_done", cnt, 32'd0);
    issue(8'd0, 32'h0, 32'h1, lat, res);
    check("abort_fetch_lat", lat, 32'd1);
    check("abort_fetch_res", res, 32'h0);

    // Start coinciding with reset is discarded.
    @(posedge clock); #1;
    reset = 1'b1; start = 1'b1; valueA = 32'hFFFF_FFFF; valueB = 32'h0;
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0;
    count_done(8, cnt);
    check("start_in_reset_no_done", cnt, 32'd0);
    issue(8'd0, 32'h0, 32'h1, lat, res);
    check("start_in_reset_fetch", res, 32'h0);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
